// File: rtl/seq_detector_param_if.sv
// Serial-stream bus of the parametrised pattern detector.
// pat_mask_in exists only when SEQ_DET_MASK_EN is defined.
interface seq_detector_param_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
);
  logic             din_valid;
  logic             din;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic             overlap_in;
`ifdef SEQ_DET_MASK_EN
  logic [N-1:0]     pat_mask_in;
`endif
  logic             cnt_clr;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output din_valid, din, pat_load, pat_in, overlap_in, cnt_clr,
`ifdef SEQ_DET_MASK_EN
    output pat_mask_in,
`endif
    input  dout, match_cnt
  );

  modport slave (
    input  din_valid, din, pat_load, pat_in, overlap_in, cnt_clr,
`ifdef SEQ_DET_MASK_EN
    input  pat_mask_in,
`endif
    output dout, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with loadable pattern/overlap mode and a
// saturating match counter. SEQ_DET_MASK_EN adds a loadable don't-care mask.
module seq_detector_param #(
  parameter int unsigned    N           = 4,
  parameter logic [N-1:0]   PAT_RST     = N'(4'b0110),
  parameter bit             OVERLAP_RST = 1'b1,
  parameter int unsigned    CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_detector_param_if.slave bus
);
  localparam int unsigned    FW      = $clog2(N);
  localparam logic [FW-1:0]  FillMax = FW'(N - 1);

  logic [N-1:0]     pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [N-2:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     window;
  logic [N-1:0]     diff;
  logic             dout;

  // Newest bit sits at the LSB so pattern bit N-1 lines up with the oldest accepted bit.
  assign window = {hist_q, bus.din};

`ifdef SEQ_DET_MASK_EN
  logic [N-1:0] mask_q, mask_d;
  assign diff = (window ^ pat_q) & mask_q;
`else
  assign diff = window ^ pat_q;
`endif

  assign dout = bus.din_valid & ~bus.pat_load & ~rst & (fill_q == FillMax) & (diff == '0);

  assign bus.dout      = dout;
  assign bus.match_cnt = cnt_q;

  always_comb begin
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
`ifdef SEQ_DET_MASK_EN
    mask_d = mask_q;
`endif

    if (bus.pat_load) begin
      // A load drops the offered bit and restarts the fill count.
      pat_d  = bus.pat_in;
      ovl_d  = bus.overlap_in;
      fill_d = '0;
`ifdef SEQ_DET_MASK_EN
      mask_d = bus.pat_mask_in;
`endif
    end else if (bus.din_valid) begin
      hist_d = window[N-2:0];
      if (dout && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (dout && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      ovl_q  <= OVERLAP_RST;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
`ifdef SEQ_DET_MASK_EN
      mask_q <= '1;
`endif
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
`ifdef SEQ_DET_MASK_EN
      mask_q <= mask_d;
`endif
    end
  end
endmodule
